// File: rtl/pkt_dmux_pkg.sv
// Shared definitions for the UM packet-bus demultiplexer: tags, FSM states and
// header field offsets.
package pkt_dmux_pkg;

    localparam int WORD_W = 134;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_MID  = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    localparam int TAG_HI   = 133;
    localparam int TAG_LO   = 132;
    localparam int DMAC_HI  = 127;
    localparam int DMAC_LO  = 80;
    localparam int ETYPE_HI = 31;
    localparam int ETYPE_LO = 16;
    localparam int PTYPE_HI = 15;
    localparam int PTYPE_LO = 0;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    // PTP message types that a switch terminates locally when addressed to it.
    localparam int NUM_PTP_UNI = 2;
    localparam logic [NUM_PTP_UNI-1:0][15:0] PTP_UNI_TYPES = {16'h0401, 16'h0301};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HDR,
        ST_STREAM,
        ST_FLUSH,
        ST_DROP
    } state_t;

    function automatic logic is_ptp_uni(input logic [15:0] ptype);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_PTP_UNI; k++) begin
            if (ptype == PTP_UNI_TYPES[k]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pkt_dmux_classify.sv
// Combinational destination lookup: PTP handling by device role, otherwise the
// lowest-index enabled ethertype rule, otherwise the default mask.
module pkt_dmux_classify
    import pkt_dmux_pkg::*;
#(
    parameter int          NUM_OUT   = 4,
    parameter int          NUM_RULES = 4,
    parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
    input  logic [47:0]                  i_dmac,
    input  logic [15:0]                  i_etype,
    input  logic [15:0]                  i_ptype,
    input  logic [47:0]                  i_device_mac,
    input  logic [1:0]                   i_device_role,
    input  logic [NUM_OUT-1:0]           i_cfg_fwd_mask,
    input  logic [NUM_OUT-1:0]           i_cfg_dflt_mask,
    input  logic [NUM_RULES-1:0]         i_cfg_rule_en,
    input  logic [16*NUM_RULES-1:0]      i_cfg_rule_etype,
    input  logic [NUM_OUT*NUM_RULES-1:0] i_cfg_rule_mask,
    output logic [NUM_OUT-1:0]           o_mask
);

    localparam logic [NUM_OUT-1:0] LOCAL_CH = {{(NUM_OUT-1){1'b0}}, 1'b1};

    logic               w_is_ptp;
    logic               w_to_me;
    logic               w_bcast;
    logic [NUM_OUT-1:0] w_fwd;
    logic [NUM_OUT-1:0] w_rule_mask;

    assign w_is_ptp = (i_etype == PTP_ETYPE);
    assign w_to_me  = (i_dmac == i_device_mac);
    assign w_bcast  = (i_dmac == BCAST_MAC);
    assign w_fwd    = i_cfg_fwd_mask & ~LOCAL_CH;

    // Scan from the top so the lowest-index matching rule is the last writer.
    always_comb begin
        w_rule_mask = i_cfg_dflt_mask;
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (i_cfg_rule_en[r] && (i_cfg_rule_etype[16*r +: 16] == i_etype)) begin
                w_rule_mask = i_cfg_rule_mask[NUM_OUT*r +: NUM_OUT];
            end
        end
    end

    always_comb begin
        o_mask = w_rule_mask;
        if (w_is_ptp && i_device_role[1]) begin
            if (w_to_me && is_ptp_uni(i_ptype)) begin
                o_mask = LOCAL_CH;
            end else if (w_bcast) begin
                o_mask = i_device_role[0] ? '0 : (LOCAL_CH | w_fwd);
            end else begin
                o_mask = w_fwd;
            end
        end else if (w_is_ptp) begin
            o_mask = (w_to_me || w_bcast) ? LOCAL_CH : '0;
        end
    end

endmodule

// File: rtl/pkt_dmux_n.sv
// N-way UM packet demultiplexer: holds metadata until word 1 is classified,
// then streams the packet one word behind the input to a channel bitmask.
module pkt_dmux_n
    import pkt_dmux_pkg::*;
#(
    parameter int          NUM_OUT   = 4,
    parameter int          NUM_RULES = 4,
    parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_data_wr,
    input  logic [WORD_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [WORD_W-1:0]            out_data,
    output logic [NUM_OUT-1:0]           out_data_wr,
    output logic                         out_valid,
    output logic [NUM_OUT-1:0]           out_valid_wr,
    input  logic [NUM_OUT-1:0]           out_alf,
    input  logic [47:0]                  device_mac,
    input  logic [1:0]                   device_role,
    input  logic [NUM_OUT-1:0]           cfg_fwd_mask,
    input  logic [NUM_OUT-1:0]           cfg_dflt_mask,
    input  logic [NUM_RULES-1:0]         cfg_rule_en,
    input  logic [16*NUM_RULES-1:0]      cfg_rule_etype,
    input  logic [NUM_OUT*NUM_RULES-1:0] cfg_rule_mask,
    output logic [32*NUM_OUT-1:0]        cnt_pkt,
    output logic [31:0]                  cnt_drop,
    output logic [15:0]                  cnt_abort
);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_meta;
    logic [WORD_W-1:0]   r_dly_p1;
    logic [NUM_OUT-1:0]  r_mask;
    logic [WORD_W-1:0]   r_out_data;
    logic [NUM_OUT-1:0]  r_out_data_wr;
    logic [NUM_OUT-1:0]  r_out_valid_wr;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [31:0]         r_cnt_drop;
    logic [15:0]         r_cnt_abort;

    logic [WORD_W-1:0]   w_meta_nxt;
    logic [WORD_W-1:0]   w_dly_nxt;
    logic [NUM_OUT-1:0]  w_mask_nxt;
    logic [WORD_W-1:0]   w_out_data_nxt;
    logic [NUM_OUT-1:0]  w_out_data_wr_nxt;
    logic [NUM_OUT-1:0]  w_out_valid_wr_nxt;
    logic                w_out_valid_nxt;
    logic                w_in_ready_nxt;
    logic                w_pkt_inc;
    logic                w_drop_inc;
    logic                w_abort_inc;

    logic [1:0]          w_tag;
    logic                w_head;
    logic                w_tail;
    logic [NUM_OUT-1:0]  w_cls_mask;

    assign w_tag  = in_data[TAG_HI:TAG_LO];
    assign w_head = in_data_wr && (w_tag == TAG_HEAD);
    assign w_tail = in_data_wr && (w_tag == TAG_TAIL);

    pkt_dmux_classify #(
        .NUM_OUT   (NUM_OUT),
        .NUM_RULES (NUM_RULES),
        .PTP_ETYPE (PTP_ETYPE)
    ) u_classify (
        .i_dmac           (in_data[DMAC_HI:DMAC_LO]),
        .i_etype          (in_data[ETYPE_HI:ETYPE_LO]),
        .i_ptype          (in_data[PTYPE_HI:PTYPE_LO]),
        .i_device_mac     (device_mac),
        .i_device_role    (device_role),
        .i_cfg_fwd_mask   (cfg_fwd_mask),
        .i_cfg_dflt_mask  (cfg_dflt_mask),
        .i_cfg_rule_en    (cfg_rule_en),
        .i_cfg_rule_etype (cfg_rule_etype),
        .i_cfg_rule_mask  (cfg_rule_mask),
        .o_mask           (w_cls_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_head) w_state_nxt = ST_WAIT_HDR;
            end
            ST_WAIT_HDR: begin
                if (in_data_wr && !w_head) begin
                    if (w_cls_mask == '0) w_state_nxt = w_tail ? ST_IDLE : ST_DROP;
                    else                  w_state_nxt = w_tail ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_head)      w_state_nxt = ST_WAIT_HDR;
                else if (w_tail) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                w_state_nxt = w_head ? ST_WAIT_HDR : ST_IDLE;
            end
            ST_DROP: begin
                if (w_head)      w_state_nxt = ST_WAIT_HDR;
                else if (w_tail) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_meta_nxt         = r_meta;
        w_dly_nxt          = r_dly_p1;
        w_mask_nxt         = r_mask;
        w_out_data_nxt     = r_out_data;
        w_out_data_wr_nxt  = '0;
        w_out_valid_wr_nxt = '0;
        w_out_valid_nxt    = 1'b0;
        w_pkt_inc          = 1'b0;
        w_drop_inc         = 1'b0;
        w_abort_inc        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DROP: begin
                if (w_head) w_meta_nxt = in_data;
            end
            ST_WAIT_HDR: begin
                if (w_head) begin
                    w_meta_nxt = in_data;
                end else if (in_data_wr) begin
                    if (w_cls_mask == '0) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        w_out_data_nxt    = r_meta;
                        w_out_data_wr_nxt = w_cls_mask;
                        w_mask_nxt        = w_cls_mask;
                        w_dly_nxt         = in_data;
                    end
                end
            end
            ST_STREAM: begin
                if (w_head) begin
                    // Close the truncated packet downstream as a discarded tail.
                    w_out_data_nxt     = {TAG_TAIL, r_dly_p1[TAG_LO-1:0]};
                    w_out_data_wr_nxt  = r_mask;
                    w_out_valid_wr_nxt = r_mask;
                    w_meta_nxt         = in_data;
                    w_abort_inc        = 1'b1;
                end else if (in_data_wr) begin
                    w_out_data_nxt    = r_dly_p1;
                    w_out_data_wr_nxt = r_mask;
                    w_dly_nxt         = in_data;
                end
            end
            ST_FLUSH: begin
                w_out_data_nxt     = r_dly_p1;
                w_out_data_wr_nxt  = r_mask;
                w_out_valid_wr_nxt = r_mask;
                w_out_valid_nxt    = 1'b1;
                w_pkt_inc          = 1'b1;
                if (w_head) w_meta_nxt = in_data;
            end
            default: ;
        endcase
    end

    // Ready is registered, so it looks at the state and mask being entered.
    always_comb begin
        case (w_state_nxt)
            ST_STREAM, ST_FLUSH: w_in_ready_nxt = ~|(out_alf & w_mask_nxt);
            ST_DROP:             w_in_ready_nxt = 1'b1;
            default:             w_in_ready_nxt = ~|out_alf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta         <= '0;
            r_dly_p1       <= '0;
            r_mask         <= '0;
            r_out_data     <= '0;
            r_out_data_wr  <= '0;
            r_out_valid_wr <= '0;
            r_out_valid    <= 1'b0;
            r_in_ready     <= 1'b0;
            r_cnt_drop     <= '0;
            r_cnt_abort    <= '0;
        end else begin
            r_meta         <= w_meta_nxt;
            r_dly_p1       <= w_dly_nxt;
            r_mask         <= w_mask_nxt;
            r_out_data     <= w_out_data_nxt;
            r_out_data_wr  <= w_out_data_wr_nxt;
            r_out_valid_wr <= w_out_valid_wr_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_in_ready     <= w_in_ready_nxt;
            if (w_drop_inc)  r_cnt_drop  <= sat_inc32(r_cnt_drop);
            if (w_abort_inc) r_cnt_abort <= sat_inc16(r_cnt_abort);
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst)                       r_cnt <= '0;
            else if (w_pkt_inc && r_mask[g]) r_cnt <= sat_inc32(r_cnt);
        end
        assign cnt_pkt[32*g +: 32] = r_cnt;
    end

    assign in_ready     = r_in_ready;
    assign out_data     = r_out_data;
    assign out_data_wr  = r_out_data_wr;
    assign out_valid    = r_out_valid;
    assign out_valid_wr = r_out_valid_wr;
    assign cnt_drop     = r_cnt_drop;
    assign cnt_abort    = r_cnt_abort;

endmodule

// File: tb/tb_pkt_dmux_n.sv
// Directed bench for pkt_dmux_n with NUM_OUT=4: classification, streaming order,
// back-to-back packets, abort, backpressure and counters.
module tb_pkt_dmux_n;

    localparam int NO = 4;
    localparam int NR = 4;
    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] MD = 2'b11;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [47:0] MYMAC = 48'h0011_2233_4455;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_data_wr;
    logic [133:0]      in_data;
    logic              in_ready;
    logic [133:0]      out_data;
    logic [NO-1:0]     out_data_wr;
    logic              out_valid;
    logic [NO-1:0]     out_valid_wr;
    logic [NO-1:0]     out_alf;
    logic [47:0]       device_mac;
    logic [1:0]        device_role;
    logic [NO-1:0]     cfg_fwd_mask;
    logic [NO-1:0]     cfg_dflt_mask;
    logic [NR-1:0]     cfg_rule_en;
    logic [16*NR-1:0]  cfg_rule_etype;
    logic [NO*NR-1:0]  cfg_rule_mask;
    logic [32*NO-1:0]  cnt_pkt;
    logic [31:0]       cnt_drop;
    logic [15:0]       cnt_abort;

    pkt_dmux_n #(.NUM_OUT(NO), .NUM_RULES(NR), .PTP_ETYPE(16'h88F7)) dut (
        .clk(clk), .rst(rst), .in_data_wr(in_data_wr), .in_data(in_data),
        .in_ready(in_ready), .out_data(out_data), .out_data_wr(out_data_wr),
        .out_valid(out_valid), .out_valid_wr(out_valid_wr), .out_alf(out_alf),
        .device_mac(device_mac), .device_role(device_role),
        .cfg_fwd_mask(cfg_fwd_mask), .cfg_dflt_mask(cfg_dflt_mask),
        .cfg_rule_en(cfg_rule_en), .cfg_rule_etype(cfg_rule_etype),
        .cfg_rule_mask(cfg_rule_mask), .cnt_pkt(cnt_pkt), .cnt_drop(cnt_drop),
        .cnt_abort(cnt_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [133:0] d;
        logic [3:0]   wr;
        logic [3:0]   vwr;
        logic         v;
        int           cyc;
    } ev_t;

    ev_t          q[$];
    logic [133:0] ew[16];
    int           en = 0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && ((|out_data_wr) || (|out_valid_wr))) begin
            q.push_back('{d: out_data, wr: out_data_wr, vwr: out_valid_wr, v: out_valid, cyc: cyc});
        end
    end

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] w1(input logic [1:0] tag, input logic [47:0] dmac,
                                        input logic [15:0] et, input logic [15:0] pt);
        return {tag, 4'h0, dmac, 48'hC0DE_0000_BEEF, et, pt};
    endfunction

    function automatic logic [133:0] mw(input logic [1:0] tag, input logic [31:0] id);
        return {tag, 68'h0, 32'hA5A5_5A5A, id};
    endfunction

    task automatic send(input logic [133:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        in_data_wr = 1'b1;
        in_data    = w;
        @(posedge clk); #1;
        in_data_wr = 1'b0;
    endtask

    task automatic sendx(input logic [133:0] w);
        ew[en] = w;
        en++;
        send(w);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_seg(input string tag, input int base, input int n,
                             input logic [3:0] mask, input logic vld, input bit contig);
        for (int i = base; i < base + n; i++) begin
            if (i < q.size()) begin
                chk($sformatf("%s_data%0d", tag, i), q[i].d, ew[i]);
                chk($sformatf("%s_wr%0d", tag, i), q[i].wr, mask);
                if (i == base + n - 1) begin
                    chk($sformatf("%s_vwr%0d", tag, i), q[i].vwr, mask);
                    chk($sformatf("%s_valid%0d", tag, i), q[i].v, vld);
                end else begin
                    chk($sformatf("%s_vwr%0d", tag, i), q[i].vwr, 4'b0000);
                end
                if (contig && i > 0) chk($sformatf("%s_gap%0d", tag, i), q[i].cyc - q[i-1].cyc, 1);
            end
        end
    endtask

    task automatic clear_obs();
        q.delete();
        en = 0;
    endtask

    initial begin
        rst = 1'b1;
        in_data_wr = 1'b0;
        in_data = '0;
        out_alf = '0;
        device_mac = MYMAC;
        device_role = 2'b10;
        cfg_fwd_mask = 4'b1110;
        cfg_dflt_mask = 4'b1000;
        cfg_rule_en = 4'b0011;
        cfg_rule_etype = {16'h0000, 16'h86DD, 16'h0800, 16'h0800};
        cfg_rule_mask = {4'b0000, 4'b0001, 4'b1001, 4'b0110};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data_wr", out_data_wr, 0);
        chk("rst_out_valid_wr", out_valid_wr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt_pkt", cnt_pkt, 0);
        chk("rst_cnt_drop", cnt_drop, 0);
        chk("rst_cnt_abort", cnt_abort, 0);
        rst = 1'b0;

        // Non-PTP, rule 0 wins over rule 1: five words to 0110.
        sendx(mw(HD, 32'h100));
        sendx(w1(MD, 48'h0A0B_0C0D_0E0F, 16'h0800, 16'h0000));
        sendx(mw(MD, 32'h102));
        sendx(mw(MD, 32'h103));
        sendx(mw(TL, 32'h104));
        settle();
        chk("t1_count", q.size(), 5);
        check_seg("t1", 0, 5, 4'b0110, 1'b1, 1'b1);
        chk("t1_cnt0", cnt_pkt[31:0], 0);
        chk("t1_cnt1", cnt_pkt[63:32], 1);
        chk("t1_cnt2", cnt_pkt[95:64], 1);
        chk("t1_cnt3", cnt_pkt[127:96], 0);
        clear_obs();

        // PTP broadcast as switch slave: local plus forwarding.
        sendx(mw(HD, 32'h200));
        sendx(w1(MD, BCAST, 16'h88F7, 16'h0000));
        sendx(mw(TL, 32'h202));
        settle();
        chk("t2a_count", q.size(), 3);
        check_seg("t2a", 0, 3, 4'b1111, 1'b1, 1'b1);
        clear_obs();

        // Same as master: dropped.
        device_role = 2'b11;
        sendx(mw(HD, 32'h210));
        sendx(w1(MD, BCAST, 16'h88F7, 16'h0000));
        sendx(mw(TL, 32'h212));
        settle();
        chk("t2b_count", q.size(), 0);
        chk("t2b_cnt_drop", cnt_drop, 1);
        clear_obs();

        // Non-switch role: PTP to own MAC goes local only.
        device_role = 2'b00;
        sendx(mw(HD, 32'h300));
        sendx(w1(MD, MYMAC, 16'h88F7, 16'h0100));
        sendx(mw(TL, 32'h302));
        settle();
        chk("t3a_count", q.size(), 3);
        check_seg("t3a", 0, 3, 4'b0001, 1'b1, 1'b1);
        clear_obs();

        sendx(mw(HD, 32'h310));
        sendx(w1(MD, 48'h0000_0000_0001, 16'h88F7, 16'h0100));
        sendx(mw(MD, 32'h312));
        sendx(mw(TL, 32'h313));
        settle();
        chk("t3b_count", q.size(), 0);
        chk("t3b_cnt_drop", cnt_drop, 2);
        clear_obs();

        sendx(mw(HD, 32'h320));
        sendx(w1(MD, 48'h0000_0000_0002, 16'h0800, 16'h0000));
        sendx(mw(TL, 32'h322));
        settle();
        chk("t3c_count", q.size(), 3);
        check_seg("t3c", 0, 3, 4'b0110, 1'b1, 1'b1);
        clear_obs();

        // Back-to-back: second head lands in the FLUSH cycle; disabled 86DD rule -> default.
        sendx(mw(HD, 32'h400));
        sendx(w1(MD, 48'h0000_0000_0003, 16'h0800, 16'h0000));
        sendx(mw(TL, 32'h402));
        sendx(mw(HD, 32'h410));
        sendx(w1(MD, 48'h0000_0000_0004, 16'h86DD, 16'h0000));
        sendx(mw(TL, 32'h412));
        settle();
        chk("t4_count", q.size(), 6);
        check_seg("t4a", 0, 3, 4'b0110, 1'b1, 1'b1);
        check_seg("t4b", 3, 3, 4'b1000, 1'b1, 1'b1);
        clear_obs();

        // Head mid-stream: forced discard tail, then new packet.
        sendx(mw(HD, 32'h500));
        sendx(w1(MD, 48'h0000_0000_0005, 16'h0800, 16'h0000));
        sendx(mw(MD, 32'h502));
        sendx(mw(HD, 32'h510));
        sendx(w1(MD, 48'h0000_0000_0006, 16'h0800, 16'h0000));
        sendx(mw(TL, 32'h512));
        settle();
        ew[2] = mw(TL, 32'h502);
        chk("t5_count", q.size(), 6);
        check_seg("t5a", 0, 3, 4'b0110, 1'b0, 1'b1);
        check_seg("t5b", 3, 3, 4'b0110, 1'b1, 1'b1);
        chk("t5_cnt_abort", cnt_abort, 1);
        clear_obs();

        // Almost-full on a destination channel stalls the source.
        sendx(mw(HD, 32'h600));
        sendx(w1(MD, 48'h0000_0000_0007, 16'h0800, 16'h0000));
        out_alf = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        chk("t6a_in_ready", in_ready, 0);
        chk("t6a_stall_count", q.size(), 1);
        out_alf = 4'b0000;
        sendx(mw(MD, 32'h602));
        sendx(mw(TL, 32'h603));
        settle();
        chk("t6a_count", q.size(), 4);
        check_seg("t6a", 0, 4, 4'b0110, 1'b1, 1'b0);
        clear_obs();

        // Almost-full on a channel outside the mask does not stall.
        sendx(mw(HD, 32'h610));
        sendx(w1(MD, 48'h0000_0000_0008, 16'h0800, 16'h0000));
        out_alf = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        chk("t6b_in_ready", in_ready, 1);
        sendx(mw(MD, 32'h612));
        out_alf = 4'b0000;
        sendx(mw(TL, 32'h613));
        settle();
        chk("t6b_count", q.size(), 4);
        check_seg("t6b", 0, 4, 4'b0110, 1'b1, 1'b0);
        clear_obs();

        chk("end_cnt0", cnt_pkt[31:0], 2);
        chk("end_cnt1", cnt_pkt[63:32], 7);
        chk("end_cnt2", cnt_pkt[95:64], 7);
        chk("end_cnt3", cnt_pkt[127:96], 2);
        chk("end_cnt_drop", cnt_drop, 2);
        chk("end_cnt_abort", cnt_abort, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
